instr_ram_arbiter: RTL

//  Shares the single-port instruction RAM (boot ROM + SRAM wrap) between the core

---
 rtl/instr_ram_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_ram_arbiter.sv
// Purpose: shares the single-port instruction RAM between core fetch and the external port.
// Latency: grant is combinational in the request cycle; rvalid/rdata follow exactly 1 cycle later.
// Backpressure: core has priority; ext_req_i waits at most STARVE_MAX consecutive core grants.
module instr_ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    input  logic                    ext_req_i,
    input  logic                    ext_we_i,
    input  logic [ADDR_WIDTH-1:0]   ext_addr_i,
    input  logic [DATA_WIDTH-1:0]   ext_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] ext_be_i,
    output logic                    ext_gnt_o,
    output logic                    ext_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ext_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(STARVE_MAX + 1);
    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_EXT  = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_MAX);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } ram_req_t;

    logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
    logic                 valid_q, valid_d;
    logic                 owner_q, owner_d;
    logic                 core_gnt, ext_gnt;
    ram_req_t             ram_req;

    // Ext only overrides a requesting core once the core has had STARVE_MAX turns.
    always_comb begin
        ext_gnt  = ext_req_i & (~core_req_i | (starve_cnt_q == CNT_MAX));
        core_gnt = core_req_i & ~ext_gnt;
    end

    always_comb begin
        ram_req.we    = 1'b0;
        ram_req.addr  = core_addr_i;
        ram_req.wdata = '0;
        ram_req.be    = '1;
        if (ext_gnt) begin
            ram_req.we    = ext_we_i;
            ram_req.addr  = ext_addr_i;
            ram_req.wdata = ext_wdata_i;
            ram_req.be    = ext_be_i;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ext_gnt || !ext_req_i) begin
            starve_cnt_d = '0;
        end else if (core_gnt && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        valid_d = core_gnt | ext_gnt;
        owner_d = ext_gnt ? OWNER_EXT : OWNER_CORE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            valid_q      <= 1'b0;
            owner_q      <= OWNER_CORE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            owner_q      <= owner_d;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign ext_gnt_o     = ext_gnt;
    assign ram_en_o      = core_gnt | ext_gnt;
    assign ram_we_o      = ram_req.we;
    assign ram_addr_o    = ram_req.addr;
    assign ram_wdata_o   = ram_req.wdata;
    assign ram_be_o      = ram_req.be;

    // Write acks ride the same rvalid path; rdata is meaningless for them.
    assign core_rvalid_o = valid_q & (owner_q == OWNER_CORE);
    assign ext_rvalid_o  = valid_q & (owner_q == OWNER_EXT);
    assign core_rdata_o  = ram_rdata_i;
    assign ext_rdata_o   = ram_rdata_i;

endmodule
